lsq_issue: RTL and testbench
============================

LSQ_ISSUE -- requirements
Module: lsq_issue

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data/address width.
REQ-002 SHALL have parameter ROB_WIDTH, default 4, ROB tag width.
REQ-003 SHALL have parameter PREG_WIDTH, default 7, physical register index width.
REQ-004 SHALL have parameter DEPTH, default 4, queue entries (power of 2, >=2).
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port i_valid  in  1  enqueue request from dispatch.
REQ-008 SHALL have port i_base_addr  in  DATA_WIDTH  rs1 value.
REQ-009 SHALL have port i_offset  in  DATA_WIDTH  immediate.
REQ-010 SHALL have port i_store_data  in  DATA_WIDTH  rs2 value.
REQ-011 SHALL have port i_memwrite  in  1  1=store, 0=load.
REQ-012 SHALL have port i_prd  in  PREG_WIDTH  load destination register.
REQ-013 SHALL have port i_rob_tag  in  ROB_WIDTH  op ROB tag.
REQ-014 SHALL have port o_ready  out  1  queue can accept this cycle.
REQ-015 SHALL have port i_rob_head_tag  in  ROB_WIDTH  tag of oldest uncommitted ROB entry.
REQ-016 SHALL have port i_flush  in  1  squash all queued and in-flight ops.
REQ-017 SHALL have port o_lsu_valid  out  1  issue strobe to LSU pipe.
REQ-018 SHALL have port o_lsu_base_addr  out  DATA_WIDTH  issued rs1.
REQ-019 SHALL have port o_lsu_offset  out  DATA_WIDTH  issued immediate.
REQ-020 SHALL have port o_lsu_store_data  out  DATA_WIDTH  issued rs2.
REQ-021 SHALL have port o_lsu_memwrite  out  1  issued op is store.
REQ-022 SHALL have port o_lsu_prd  out  PREG_WIDTH  issued destination.
REQ-023 SHALL have port o_lsu_rob_tag  out  ROB_WIDTH  issued tag.
REQ-024 SHALL have port i_lsu_valid  in  1  LSU completion strobe (2 cycles after issue).
REQ-025 SHALL have port i_lsu_data  in  DATA_WIDTH  LSU load data.
REQ-026 SHALL have port i_lsu_rob_tag  in  ROB_WIDTH  LSU completion tag.
REQ-027 SHALL have port o_wb_valid  out  1  writeback/ROB-complete strobe.
REQ-028 SHALL have port o_wb_data  out  DATA_WIDTH  load data; 0 for stores.
REQ-029 SHALL have port o_wb_prd  out  PREG_WIDTH  destination from in-flight tracker.
REQ-030 SHALL have port o_wb_rob_tag  out  ROB_WIDTH  completed tag.
REQ-031 SHALL have port o_error  out  1  sticky completion-order mismatch.

Function
REQ-032 SHALL hold ops in a circular FIFO of DEPTH entries with wrapping read/write pointers and a count 0..DEPTH; o_ready = (count < DEPTH) and not i_flush.
REQ-033 SHALL write an entry on i_valid && o_ready; i_valid while !o_ready SHALL be dropped with no state change.
REQ-034 SHALL issue strictly in order: o_lsu_* driven combinationally from head; o_lsu_valid=1 iff count>0, !i_flush, and (head is load, or head is store with rob_tag == i_rob_head_tag); issuing pops head same cycle.
REQ-035 SHALL NOT bypass a blocked store; loads behind it wait. No fall-through: op enqueued in cycle N issues no earlier than N+1.
REQ-036 SHALL allow simultaneous enqueue and issue at any count, including full (count unchanged) and empty-then-enqueue.
REQ-037 SHALL record each issued op (rob_tag, prd, memwrite) in a 4-entry in-flight tracker FIFO; every i_lsu_valid pops it.
REQ-038 SHALL set o_error (sticky until reset) when i_lsu_valid arrives with tracker empty or i_lsu_rob_tag != tracker head tag.
REQ-039 SHALL register writeback: o_wb_* valid one cycle after i_lsu_valid; o_wb_prd and memwrite from tracker; o_wb_data = i_lsu_data for loads, 0 for stores. Enqueue N -> issue N+1 -> LSU return N+3 -> o_wb_valid N+4.
REQ-040 SHALL on i_flush: empty the queue (count=0, pointers to 0), load a drop counter with current tracker occupancy, clear the tracker; while drop counter > 0 each i_lsu_valid decrements it and produces no writeback and no o_error.
REQ-041 SHALL let i_flush dominate i_valid in the same cycle; stores already issued are not recalled.

Reset
REQ-042 SHALL, while reset=0, asynchronously clear count, pointers, tracker, drop counter, o_error, and all o_wb_* registers to 0; o_ready=1, o_lsu_valid=0 after release; mid-operation reset discards all entries and pending completions.

Verification
REQ-043 Load enqueued cycle 0 (base 0x100, offset 0x8, prd 5, tag 3), LSU returns tag 3 data 0x42 cycle 3 -> o_lsu_valid cycle 1 only; o_wb_valid cycle 4 with data 0x42, prd 5, tag 3.
REQ-044 Store tag 2 then load tag 3, i_rob_head_tag=1 for 5 cycles then 2 -> no issue while head_tag=1; store issues the cycle head_tag=2, load next cycle; store writeback data 0.
REQ-045 Issue blocked, 5 enqueues back-to-back -> o_ready=0 after 4th, 5th dropped; unblock -> exactly 4 ops issue in order, pointers wrap correctly.
REQ-046 Two loads in flight, i_flush asserted -> queue empty, next two i_lsu_valid produce no o_wb_valid, o_error stays 0.
REQ-047 i_lsu_valid with tag 7 when tracker head is 6 -> o_error=1 and stays 1 until reset=0.
REQ-048 reset pulled low while 3 entries queued -> o_lsu_valid=0, o_wb_valid=0, o_ready=1 immediately, no issue after release.

Source files
------------

// File: rtl/lsq_issue_if.sv
// Signal bundle between dispatch / LSU / writeback and the load-store issue queue.
// The slave modport is the queue's view; the master modport is the surrounding pipeline's view.
interface lsq_issue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 7
);
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_base_addr;
    logic [DATA_WIDTH-1:0] i_offset;
    logic [DATA_WIDTH-1:0] i_store_data;
    logic                  i_memwrite;
    logic [PREG_WIDTH-1:0] i_prd;
    logic [ROB_WIDTH-1:0]  i_rob_tag;
    logic                  o_ready;
    logic [ROB_WIDTH-1:0]  i_rob_head_tag;
    logic                  i_flush;

    logic                  o_lsu_valid;
    logic [DATA_WIDTH-1:0] o_lsu_base_addr;
    logic [DATA_WIDTH-1:0] o_lsu_offset;
    logic [DATA_WIDTH-1:0] o_lsu_store_data;
    logic                  o_lsu_memwrite;
    logic [PREG_WIDTH-1:0] o_lsu_prd;
    logic [ROB_WIDTH-1:0]  o_lsu_rob_tag;

    logic                  i_lsu_valid;
    logic [DATA_WIDTH-1:0] i_lsu_data;
    logic [ROB_WIDTH-1:0]  i_lsu_rob_tag;

    logic                  o_wb_valid;
    logic [DATA_WIDTH-1:0] o_wb_data;
    logic [PREG_WIDTH-1:0] o_wb_prd;
    logic [ROB_WIDTH-1:0]  o_wb_rob_tag;
    logic                  o_error;

    modport slave (
        input  i_valid, i_base_addr, i_offset, i_store_data, i_memwrite, i_prd, i_rob_tag,
        input  i_rob_head_tag, i_flush,
        input  i_lsu_valid, i_lsu_data, i_lsu_rob_tag,
        output o_ready,
        output o_lsu_valid, o_lsu_base_addr, o_lsu_offset, o_lsu_store_data,
        output o_lsu_memwrite, o_lsu_prd, o_lsu_rob_tag,
        output o_wb_valid, o_wb_data, o_wb_prd, o_wb_rob_tag, o_error
    );

    modport master (
        output i_valid, i_base_addr, i_offset, i_store_data, i_memwrite, i_prd, i_rob_tag,
        output i_rob_head_tag, i_flush,
        output i_lsu_valid, i_lsu_data, i_lsu_rob_tag,
        input  o_ready,
        input  o_lsu_valid, o_lsu_base_addr, o_lsu_offset, o_lsu_store_data,
        input  o_lsu_memwrite, o_lsu_prd, o_lsu_rob_tag,
        input  o_wb_valid, o_wb_data, o_wb_prd, o_wb_rob_tag, o_error
    );
endinterface

// File: rtl/lsq_issue.sv
// In-order load/store issue queue: circular op FIFO, head-of-ROB gating for stores,
// in-flight tracker matching LSU completions, and a registered writeback stage.
module lsq_issue #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 7,
    parameter int DEPTH      = 4
) (
    input  logic        clk,
    input  logic        reset,
    lsq_issue_if.slave  bus
);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int TRK_DEPTH = 4;
    localparam int TRK_PTR_W = 2;
    localparam int TRK_CNT_W = 3;

    logic [DATA_WIDTH-1:0] base_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] off_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] sdata_mem [DEPTH];
    logic                  mw_mem    [DEPTH];
    logic [PREG_WIDTH-1:0] prd_mem   [DEPTH];
    logic [ROB_WIDTH-1:0]  tag_mem   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [ROB_WIDTH-1:0]  trk_tag_mem [TRK_DEPTH];
    logic [PREG_WIDTH-1:0] trk_prd_mem [TRK_DEPTH];
    logic                  trk_mw_mem  [TRK_DEPTH];

    logic [TRK_PTR_W-1:0] trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;
    logic [TRK_CNT_W-1:0] trk_cnt_q, trk_cnt_d, drop_q, drop_d;

    logic                  wb_valid_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [PREG_WIDTH-1:0] wb_prd_q;
    logic [ROB_WIDTH-1:0]  wb_tag_q;
    logic                  err_q;

    logic ready, enq, issue, head_mw;
    logic dropping, cpl, trk_empty, trk_pop, mismatch;

    assign ready   = (count_q != CNT_W'(DEPTH)) && !bus.i_flush;
    assign enq     = bus.i_valid && ready;
    assign head_mw = mw_mem[rd_ptr_q];
    // A store may only leave the queue once it is the oldest uncommitted ROB entry.
    assign issue   = (count_q != '0) && !bus.i_flush &&
                     (!head_mw || (tag_mem[rd_ptr_q] == bus.i_rob_head_tag));

    assign bus.o_ready          = ready;
    assign bus.o_lsu_valid      = issue;
    assign bus.o_lsu_base_addr  = base_mem[rd_ptr_q];
    assign bus.o_lsu_offset     = off_mem[rd_ptr_q];
    assign bus.o_lsu_store_data = sdata_mem[rd_ptr_q];
    assign bus.o_lsu_memwrite   = head_mw;
    assign bus.o_lsu_prd        = prd_mem[rd_ptr_q];
    assign bus.o_lsu_rob_tag    = tag_mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (enq) begin
            base_mem[wr_ptr_q]  <= bus.i_base_addr;
            off_mem[wr_ptr_q]   <= bus.i_offset;
            sdata_mem[wr_ptr_q] <= bus.i_store_data;
            mw_mem[wr_ptr_q]    <= bus.i_memwrite;
            prd_mem[wr_ptr_q]   <= bus.i_prd;
            tag_mem[wr_ptr_q]   <= bus.i_rob_tag;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq)   wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (issue) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (enq && !issue)      count_d = count_q + CNT_W'(1);
            else if (!enq && issue) count_d = count_q - CNT_W'(1);
        end
    end

    // Completions still owed to squashed ops are swallowed by the drop counter.
    assign dropping  = (drop_q != '0);
    assign cpl       = bus.i_lsu_valid && !dropping;
    assign trk_empty = (trk_cnt_q == '0);
    assign trk_pop   = cpl && !trk_empty;
    assign mismatch  = cpl && (trk_empty || (bus.i_lsu_rob_tag != trk_tag_mem[trk_rd_q]));

    always_ff @(posedge clk) begin
        if (issue) begin
            trk_tag_mem[trk_wr_q] <= tag_mem[rd_ptr_q];
            trk_prd_mem[trk_wr_q] <= prd_mem[rd_ptr_q];
            trk_mw_mem[trk_wr_q]  <= head_mw;
        end
    end

    always_comb begin
        trk_wr_d  = trk_wr_q;
        trk_rd_d  = trk_rd_q;
        trk_cnt_d = trk_cnt_q;
        drop_d    = drop_q;
        if (bus.i_lsu_valid && dropping) drop_d = drop_q - TRK_CNT_W'(1);
        if (issue)   trk_wr_d = trk_wr_q + TRK_PTR_W'(1);
        if (trk_pop) trk_rd_d = trk_rd_q + TRK_PTR_W'(1);
        if (issue && !trk_pop)      trk_cnt_d = trk_cnt_q + TRK_CNT_W'(1);
        else if (!issue && trk_pop) trk_cnt_d = trk_cnt_q - TRK_CNT_W'(1);
        if (bus.i_flush) begin
            drop_d    = drop_d + trk_cnt_d;
            trk_wr_d  = '0;
            trk_rd_d  = '0;
            trk_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            trk_wr_q   <= '0;
            trk_rd_q   <= '0;
            trk_cnt_q  <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_prd_q   <= '0;
            wb_tag_q   <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            trk_wr_q   <= trk_wr_d;
            trk_rd_q   <= trk_rd_d;
            trk_cnt_q  <= trk_cnt_d;
            drop_q     <= drop_d;
            err_q      <= err_q | mismatch;
            wb_valid_q <= trk_pop;
            if (trk_pop) begin
                wb_data_q <= trk_mw_mem[trk_rd_q] ? '0 : bus.i_lsu_data;
                wb_prd_q  <= trk_prd_mem[trk_rd_q];
                wb_tag_q  <= bus.i_lsu_rob_tag;
            end
        end
    end

    assign bus.o_wb_valid   = wb_valid_q;
    assign bus.o_wb_data    = wb_data_q;
    assign bus.o_wb_prd     = wb_prd_q;
    assign bus.o_wb_rob_tag = wb_tag_q;
    assign bus.o_error      = err_q;
endmodule

// File: tb/tb_lsq_issue.sv
// Directed bench for lsq_issue: linear sequence of hand-computed steps, checked with immediate assertions.
module tb_lsq_issue;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    lsq_issue_if bus_if ();

    lsq_issue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] base, input logic [31:0] off, input logic [31:0] sd,
                       input logic mw, input logic [6:0] prd, input logic [3:0] tag);
        bus_if.i_valid      = 1'b1;
        bus_if.i_base_addr  = base;
        bus_if.i_offset     = off;
        bus_if.i_store_data = sd;
        bus_if.i_memwrite   = mw;
        bus_if.i_prd        = prd;
        bus_if.i_rob_tag    = tag;
    endtask

    task automatic noenq();
        bus_if.i_valid = 1'b0;
    endtask

    task automatic lsu(input logic v, input logic [3:0] tag, input logic [31:0] data);
        bus_if.i_lsu_valid   = v;
        bus_if.i_lsu_rob_tag = tag;
        bus_if.i_lsu_data    = data;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        enq(0, 0, 0, 1'b0, 7'd0, 4'd0);
        noenq();
        lsu(1'b0, 4'd0, 0);
        bus_if.i_rob_head_tag = 4'd0;
        bus_if.i_flush        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus_if.o_ready, 1);
        chk("rst_lsu_valid", bus_if.o_lsu_valid, 0);
        chk("rst_wb_valid", bus_if.o_wb_valid, 0);
        chk("rst_error", bus_if.o_error, 0);
        reset = 1'b1;
        cyc();

        // Single load: enqueue c0, issue c1, LSU return c3, writeback c4
        enq(32'h100, 32'h8, 0, 1'b0, 7'd5, 4'd3); #2;
        chk("ld_ready", bus_if.o_ready, 1);
        chk("ld_no_fallthrough", bus_if.o_lsu_valid, 0);
        cyc(); noenq(); #2;
        chk("ld_issue_valid", bus_if.o_lsu_valid, 1);
        chk("ld_issue_base", bus_if.o_lsu_base_addr, 32'h100);
        chk("ld_issue_off", bus_if.o_lsu_offset, 32'h8);
        chk("ld_issue_mw", bus_if.o_lsu_memwrite, 0);
        chk("ld_issue_prd", bus_if.o_lsu_prd, 5);
        chk("ld_issue_tag", bus_if.o_lsu_rob_tag, 3);
        cyc(); #2;
        chk("ld_issue_once", bus_if.o_lsu_valid, 0);
        cyc(); lsu(1'b1, 4'd3, 32'h42); #2;
        chk("ld_wb_early", bus_if.o_wb_valid, 0);
        cyc(); lsu(1'b0, 4'd0, 0); #2;
        chk("ld_wb_valid", bus_if.o_wb_valid, 1);
        chk("ld_wb_data", bus_if.o_wb_data, 32'h42);
        chk("ld_wb_prd", bus_if.o_wb_prd, 5);
        chk("ld_wb_tag", bus_if.o_wb_rob_tag, 3);
        chk("ld_error", bus_if.o_error, 0);
        cyc(); #2;
        chk("ld_wb_once", bus_if.o_wb_valid, 0);

        // Store waits for ROB head; load behind it waits too
        cyc();
        bus_if.i_rob_head_tag = 4'd1;
        enq(32'h200, 0, 32'hDEAD, 1'b1, 7'd0, 4'd2); #2;
        chk("st_block_c0", bus_if.o_lsu_valid, 0);
        cyc(); enq(32'h300, 32'h4, 0, 1'b0, 7'd9, 4'd3); #2;
        chk("st_block_c1", bus_if.o_lsu_valid, 0);
        cyc(); noenq();
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("st_block_wait", bus_if.o_lsu_valid, 0);
            cyc();
        end
        bus_if.i_rob_head_tag = 4'd2; #2;
        chk("st_issue_valid", bus_if.o_lsu_valid, 1);
        chk("st_issue_mw", bus_if.o_lsu_memwrite, 1);
        chk("st_issue_tag", bus_if.o_lsu_rob_tag, 2);
        chk("st_issue_data", bus_if.o_lsu_store_data, 32'hDEAD);
        cyc(); #2;
        chk("st_ld_valid", bus_if.o_lsu_valid, 1);
        chk("st_ld_tag", bus_if.o_lsu_rob_tag, 3);
        chk("st_ld_mw", bus_if.o_lsu_memwrite, 0);
        cyc(); lsu(1'b1, 4'd2, 32'h55); #2;
        chk("st_idle", bus_if.o_lsu_valid, 0);
        cyc(); lsu(1'b1, 4'd3, 32'h77); #2;
        chk("st_wb_valid", bus_if.o_wb_valid, 1);
        chk("st_wb_tag", bus_if.o_wb_rob_tag, 2);
        chk("st_wb_data_zero", bus_if.o_wb_data, 0);
        cyc(); lsu(1'b0, 4'd0, 0); #2;
        chk("st_ld_wb_valid", bus_if.o_wb_valid, 1);
        chk("st_ld_wb_tag", bus_if.o_wb_rob_tag, 3);
        chk("st_ld_wb_data", bus_if.o_wb_data, 32'h77);
        chk("st_ld_wb_prd", bus_if.o_wb_prd, 9);
        chk("st_error", bus_if.o_error, 0);

        // Fill while blocked: 4 accepted, 5th dropped, then drain in order across pointer wrap
        cyc();
        bus_if.i_rob_head_tag = 4'd0;
        for (int i = 0; i < 5; i++) begin
            enq(32'h400 + 32'(i), 32'(i), 0, (i == 0), 7'(20 + i), 4'(4 + i)); #2;
            chk("full_ready", bus_if.o_ready, 32'(i < 4));
            chk("full_blocked", bus_if.o_lsu_valid, 0);
            cyc();
        end
        noenq();
        bus_if.i_rob_head_tag = 4'd4;
        for (int k = 0; k < 8; k++) begin
            if (k >= 2 && k <= 5) lsu(1'b1, 4'(4 + k - 2), 32'h1000 + 32'(k));
            else                  lsu(1'b0, 4'd0, 0);
            #2;
            chk("drain_ready", bus_if.o_ready, 32'(k != 0));
            chk("drain_valid", bus_if.o_lsu_valid, 32'(k < 4));
            if (k < 4) begin
                chk("drain_tag", bus_if.o_lsu_rob_tag, 32'(4 + k));
                chk("drain_mw", bus_if.o_lsu_memwrite, 32'(k == 0));
            end
            chk("drain_wb_valid", bus_if.o_wb_valid, 32'(k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) begin
                chk("drain_wb_tag", bus_if.o_wb_rob_tag, 32'(4 + k - 3));
                chk("drain_wb_prd", bus_if.o_wb_prd, 32'(20 + k - 3));
                chk("drain_wb_data", bus_if.o_wb_data, (k == 3) ? 32'h0 : 32'h1000 + 32'(k - 1));
            end
            cyc();
        end
        chk("drain_error", bus_if.o_error, 0);

        // Flush with two loads in flight and a blocked store queued
        bus_if.i_rob_head_tag = 4'd0;
        enq(0, 0, 0, 1'b0, 7'd11, 4'd1); #2;
        cyc(); enq(0, 0, 0, 1'b0, 7'd12, 4'd2); #2;
        chk("fl_issue1", bus_if.o_lsu_rob_tag, 1);
        cyc(); enq(0, 0, 32'h5, 1'b1, 7'd0, 4'd10); #2;
        chk("fl_issue2_valid", bus_if.o_lsu_valid, 1);
        chk("fl_issue2", bus_if.o_lsu_rob_tag, 2);
        cyc(); enq(0, 0, 0, 1'b0, 7'd13, 4'd9); bus_if.i_flush = 1'b1; #2;
        chk("fl_ready_low", bus_if.o_ready, 0);
        chk("fl_no_issue", bus_if.o_lsu_valid, 0);
        cyc(); noenq(); bus_if.i_flush = 1'b0; bus_if.i_rob_head_tag = 4'd10;
        lsu(1'b1, 4'd1, 32'hAA); #2;
        chk("fl_queue_empty", bus_if.o_lsu_valid, 0);
        chk("fl_ready_back", bus_if.o_ready, 1);
        cyc(); lsu(1'b1, 4'd2, 32'hBB); #2;
        chk("fl_no_wb1", bus_if.o_wb_valid, 0);
        cyc(); lsu(1'b0, 4'd0, 0); #2;
        chk("fl_no_wb2", bus_if.o_wb_valid, 0);
        chk("fl_error", bus_if.o_error, 0);
        chk("fl_still_empty", bus_if.o_lsu_valid, 0);

        // Completion tag mismatch sets sticky error
        cyc();
        bus_if.i_rob_head_tag = 4'd0;
        enq(0, 0, 0, 1'b0, 7'd3, 4'd6); #2;
        cyc(); noenq(); #2;
        chk("err_issue_tag", bus_if.o_lsu_rob_tag, 6);
        cyc(); #2;
        cyc(); lsu(1'b1, 4'd7, 32'h1); #2;
        chk("err_before", bus_if.o_error, 0);
        cyc(); lsu(1'b0, 4'd0, 0); #2;
        chk("err_set", bus_if.o_error, 1);
        repeat (3) cyc();
        #2;
        chk("err_sticky", bus_if.o_error, 1);

        // Asynchronous reset mid-operation with 3 stores queued
        cyc();
        for (int i = 0; i < 3; i++) begin
            enq(32'h500, 0, 0, 1'b1, 7'd0, 4'(1 + i));
            cyc();
        end
        noenq(); #2;
        chk("rst_mid_blocked", bus_if.o_lsu_valid, 0);
        reset = 1'b0;
        bus_if.i_rob_head_tag = 4'd1;
        #1;
        chk("rst_mid_lsu_valid", bus_if.o_lsu_valid, 0);
        chk("rst_mid_wb_valid", bus_if.o_wb_valid, 0);
        chk("rst_mid_ready", bus_if.o_ready, 1);
        chk("rst_mid_error", bus_if.o_error, 0);
        cyc(); cyc();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("rst_post_no_issue", bus_if.o_lsu_valid, 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
